// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the MEM-data pipeline stage: load-type encodings,
// the wait FSM state type and the default device-response timeout.
package pipeline_mem_pkg;

  // Load type encoding carried on rd_ctrl
  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;
  localparam logic [2:0] RD_LWU  = 3'b110;
  localparam logic [2:0] RD_LD   = 3'b111;

  // Cycles to wait for a device response before aborting the access
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } memd_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/half/word out of a
// 64-bit little-endian device word and sign- or zero-extends it to 64 bits.
module load_align
  import pipeline_mem_pkg::*;
(
  input  logic [2:0]  rd_ctrl,
  input  logic [2:0]  offset,
  input  logic [63:0] raw_data,
  output logic [63:0] ext_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  function automatic logic [63:0] ext8(input logic [7:0] v, input logic sgn);
    return {{56{sgn & v[7]}}, v};
  endfunction

  function automatic logic [63:0] ext16(input logic [15:0] v, input logic sgn);
    return {{48{sgn & v[15]}}, v};
  endfunction

  function automatic logic [63:0] ext32(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

  // Lane select by offset, then extend according to the load type
  always_comb begin
    // Address bits below the access size are ignored rather than faulted
    byte_v = raw_data[{offset, 3'b000} +: 8];
    half_v = raw_data[{offset[2:1], 4'b0000} +: 16];
    word_v = raw_data[{offset[2], 5'b00000} +: 32];
    ext_data = '0;
    case (rd_ctrl)
      RD_LB:   ext_data = ext8(byte_v, 1'b1);
      RD_LBU:  ext_data = ext8(byte_v, 1'b0);
      RD_LH:   ext_data = ext16(half_v, 1'b1);
      RD_LHU:  ext_data = ext16(half_v, 1'b0);
      RD_LW:   ext_data = ext32(word_v, 1'b1);
      RD_LWU:  ext_data = ext32(word_v, 1'b0);
      RD_LD:   ext_data = raw_data;
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_memd_stage.sv
// MEM-data pipeline stage: waits for DRAM or system-bus completion, freezes
// the upstream pipeline with mem_busy while waiting, aborts with a one-cycle
// bus_err after a timeout, and registers aligned load data toward WB.
module pipeline_memd_stage
  import pipeline_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_dram_MEMP,
  input  logic [63:0] pc_MEMP,
  input  logic [1:0]  rf_wr_sel_MEMP,
  input  logic        rf_wr_en_MEMP,
  input  logic [63:0] alu_result_MEMP,
  input  logic [4:0]  rd_MEMP,
  input  logic [2:0]  rd_ctrl_MEMP,
  input  logic [2:0]  wr_ctrl_MEMP,
  input  logic [63:0] dram_dout,
  input  logic        dram_ready,
  input  logic [63:0] sys_bus_dout,
  input  logic        sys_bus_ready,
  output logic        mem_busy,
  output logic        bus_err,
  output logic [63:0] pc_MEMD,
  output logic [1:0]  rf_wr_sel_MEMD,
  output logic        rf_wr_en_MEMD,
  output logic [63:0] alu_result_MEMD,
  output logic [4:0]  rd_MEMD,
  output logic [63:0] load_data_MEMD
);

  // WAIT leaves for ERR on the cycle the counter would reach this value
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  memd_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [63:0] pc_q, pc_d;
  logic [1:0]  rf_wr_sel_q, rf_wr_sel_d;
  logic        rf_wr_en_q, rf_wr_en_d;
  logic [63:0] alu_result_q, alu_result_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] load_data_q, load_data_d;

  logic        pending, sel_ready, busy, capture;
  logic [63:0] raw_data, aligned, load_value;

  assign pending    = (rd_ctrl_MEMP != RD_NONE) || (wr_ctrl_MEMP != 3'b000);
  assign sel_ready  = is_dram_MEMP ? dram_ready : sys_bus_ready;
  assign raw_data   = is_dram_MEMP ? dram_dout : sys_bus_dout;
  assign load_value = (wr_ctrl_MEMP != 3'b000) ? 64'd0 : aligned;
  assign cnt_inc    = cnt_q + 8'd1;

  load_align u_load_align (
    .rd_ctrl  (rd_ctrl_MEMP),
    .offset   (alu_result_MEMP[2:0]),
    .raw_data (raw_data),
    .ext_data (aligned)
  );

  // Next-state, busy request and next values of the WB-facing registers
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    rf_wr_sel_d  = rf_wr_sel_q;
    rf_wr_en_d   = rf_wr_en_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    load_data_d  = load_data_q;
    busy         = 1'b0;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          if (sel_ready) begin
            capture     = 1'b1;
            load_data_d = load_value;
          end else begin
            state_d    = ST_WAIT;
            cnt_d      = '0;
            busy       = 1'b1;
            rf_wr_en_d = 1'b0;
          end
        end else if (!stall) begin
          capture     = 1'b1;
          load_data_d = '0;
        end
      end
      ST_WAIT: begin
        if (sel_ready) begin
          capture     = 1'b1;
          load_data_d = load_value;
          state_d     = ST_IDLE;
        end else begin
          busy       = 1'b1;
          rf_wr_en_d = 1'b0;
          cnt_d      = cnt_inc;
          if (cnt_inc == TIMEOUT_LAST) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        // Timed-out access is dropped: no data and no register write reach WB
        load_data_d = '0;
        rf_wr_en_d  = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (capture) begin
      pc_d         = pc_MEMP;
      rf_wr_sel_d  = rf_wr_sel_MEMP;
      rf_wr_en_d   = rf_wr_en_MEMP;
      alu_result_d = alu_result_MEMP;
      rd_d         = rd_MEMP;
    end
  end

  // FSM state, timeout counter and WB pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pc_q         <= '0;
      rf_wr_sel_q  <= '0;
      rf_wr_en_q   <= 1'b0;
      alu_result_q <= '0;
      rd_q         <= '0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      rf_wr_sel_q  <= rf_wr_sel_d;
      rf_wr_en_q   <= rf_wr_en_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      load_data_q  <= load_data_d;
    end
  end

  // Combinational outputs are forced low while reset is held
  assign mem_busy = busy & reset;
  assign bus_err  = (state_q == ST_ERR) & reset;

  assign pc_MEMD         = pc_q;
  assign rf_wr_sel_MEMD  = rf_wr_sel_q;
  assign rf_wr_en_MEMD   = rf_wr_en_q;
  assign alu_result_MEMD = alu_result_q;
  assign rd_MEMD         = rd_q;
  assign load_data_MEMD  = load_data_q;

endmodule

// File: tb/tb_pipeline_memd_stage.sv
// Bench for pipeline_memd_stage: table of single-cycle accesses through a
// scoreboard queue, plus sequences for wait, timeout, reset, stall and
// wrong-device ready.
module tb_pipeline_memd_stage;
  import pipeline_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        is_dram_MEMP;
  logic [63:0] pc_MEMP;
  logic [1:0]  rf_wr_sel_MEMP;
  logic        rf_wr_en_MEMP;
  logic [63:0] alu_result_MEMP;
  logic [4:0]  rd_MEMP;
  logic [2:0]  rd_ctrl_MEMP;
  logic [2:0]  wr_ctrl_MEMP;
  logic [63:0] dram_dout;
  logic        dram_ready;
  logic [63:0] sys_bus_dout;
  logic        sys_bus_ready;
  logic        mem_busy;
  logic        bus_err;
  logic [63:0] pc_MEMD;
  logic [1:0]  rf_wr_sel_MEMD;
  logic        rf_wr_en_MEMD;
  logic [63:0] alu_result_MEMD;
  logic [4:0]  rd_MEMD;
  logic [63:0] load_data_MEMD;

  pipeline_memd_stage #(.TIMEOUT_CYCLES(255)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .is_dram_MEMP    (is_dram_MEMP),
    .pc_MEMP         (pc_MEMP),
    .rf_wr_sel_MEMP  (rf_wr_sel_MEMP),
    .rf_wr_en_MEMP   (rf_wr_en_MEMP),
    .alu_result_MEMP (alu_result_MEMP),
    .rd_MEMP         (rd_MEMP),
    .rd_ctrl_MEMP    (rd_ctrl_MEMP),
    .wr_ctrl_MEMP    (wr_ctrl_MEMP),
    .dram_dout       (dram_dout),
    .dram_ready      (dram_ready),
    .sys_bus_dout    (sys_bus_dout),
    .sys_bus_ready   (sys_bus_ready),
    .mem_busy        (mem_busy),
    .bus_err         (bus_err),
    .pc_MEMD         (pc_MEMD),
    .rf_wr_sel_MEMD  (rf_wr_sel_MEMD),
    .rf_wr_en_MEMD   (rf_wr_en_MEMD),
    .alu_result_MEMD (alu_result_MEMD),
    .rd_MEMD         (rd_MEMD),
    .load_data_MEMD  (load_data_MEMD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dram;
    logic [2:0]  rc;
    logic [2:0]  wc;
    logic [63:0] addr;
    logic [63:0] dout;
    logic        d_rdy;
    logic        b_rdy;
    logic        en;
    logic [63:0] exp_load;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  sel;
    logic        en;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic [63:0] load;
  } exp_t;

  localparam logic [63:0] D = 64'hF1E2_D3C4_B5A6_9788;

  vec_t vecs[16];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   busy_cycles = 0;
  int   err_pulses  = 0;

  // Mid-cycle monitors for busy duration and error pulses
  always @(negedge clk) begin
    if (mem_busy) busy_cycles++;
    if (bus_err)  err_pulses++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic dram, input logic [2:0] rc, input logic [2:0] wc,
                       input logic [63:0] addr, input logic [63:0] pc,
                       input logic [4:0] rd, input logic [1:0] sel, input logic en);
    is_dram_MEMP    = dram;
    rd_ctrl_MEMP    = rc;
    wr_ctrl_MEMP    = wc;
    alu_result_MEMP = addr;
    pc_MEMP         = pc;
    rd_MEMP         = rd;
    rf_wr_sel_MEMP  = sel;
    rf_wr_en_MEMP   = en;
  endtask

  task automatic nop();
    drive(1'b0, RD_NONE, 3'b000, 64'd0, 64'd0, 5'd0, 2'd0, 1'b0);
    dram_ready    = 1'b0;
    sys_bus_ready = 1'b0;
  endtask

  task automatic push(input logic [63:0] pc, input logic [1:0] sel, input logic en,
                      input logic [63:0] alu, input logic [4:0] rd, input logic [63:0] load);
    exp_t e;
    e.pc = pc; e.sel = sel; e.en = en; e.alu = alu; e.rd = rd; e.load = load;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s.sb: got empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"},   pc_MEMD,         e.pc);
      chk({tag, ".sel"},  rf_wr_sel_MEMD,  e.sel);
      chk({tag, ".en"},   rf_wr_en_MEMD,   e.en);
      chk({tag, ".alu"},  alu_result_MEMD, e.alu);
      chk({tag, ".rd"},   rd_MEMD,         e.rd);
      chk({tag, ".load"}, load_data_MEMD,  e.load);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc"},   pc_MEMD,         64'd0);
    chk({tag, ".sel"},  rf_wr_sel_MEMD,  64'd0);
    chk({tag, ".en"},   rf_wr_en_MEMD,   64'd0);
    chk({tag, ".alu"},  alu_result_MEMD, 64'd0);
    chk({tag, ".rd"},   rd_MEMD,         64'd0);
    chk({tag, ".load"}, load_data_MEMD,  64'd0);
    chk({tag, ".busy"}, mem_busy,        64'd0);
    chk({tag, ".err"},  bus_err,         64'd0);
  endtask

  initial begin
    int b0, e0;
    bit err_done;

    vecs[0]  = '{1'b1, RD_LB,   3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{1'b0, RD_LBU,  3'b000, 64'h1000_0005, D, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_00D3};
    vecs[2]  = '{1'b1, RD_LB,   3'b000, 64'h8000_0000, D, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF88};
    vecs[3]  = '{1'b0, RD_LB,   3'b000, 64'h1000_0001, D, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF97};
    vecs[4]  = '{1'b1, RD_LH,   3'b000, 64'h8000_0002, D, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_B5A6};
    vecs[5]  = '{1'b1, RD_LH,   3'b000, 64'h8000_0003, D, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_B5A6};
    vecs[6]  = '{1'b0, RD_LHU,  3'b000, 64'h1000_0006, D, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_F1E2};
    vecs[7]  = '{1'b1, RD_LW,   3'b000, 64'h8000_0000, D, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_B5A6_9788};
    vecs[8]  = '{1'b0, RD_LWU,  3'b000, 64'h1000_0004, D, 1'b0, 1'b1, 1'b1, 64'h0000_0000_F1E2_D3C4};
    vecs[9]  = '{1'b1, RD_LW,   3'b000, 64'h8000_0005, D, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_F1E2_D3C4};
    vecs[10] = '{1'b0, RD_LD,   3'b000, 64'h1000_0003, D, 1'b0, 1'b1, 1'b1, D};
    vecs[11] = '{1'b1, RD_LB,   3'b000, 64'h8000_0002, 64'h0000_0000_007F_0000, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_007F};
    vecs[12] = '{1'b1, RD_NONE, 3'b011, 64'h8000_0008, D, 1'b1, 1'b0, 1'b0, 64'd0};
    vecs[13] = '{1'b0, RD_NONE, 3'b000, 64'h1234_5678, D, 1'b1, 1'b1, 1'b1, 64'd0};
    vecs[14] = '{1'b1, RD_LHU,  3'b000, 64'h8000_0000, D, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_9788};
    vecs[15] = '{1'b1, RD_LWU,  3'b000, 64'h8000_0000, D, 1'b1, 1'b0, 1'b1, 64'h0000_0000_B5A6_9788};

    // Reset held with a pending, unready access on the inputs
    reset = 1'b0;
    stall = 1'b0;
    drive(1'b0, RD_LD, 3'b000, 64'h1000_0000, 64'h44, 5'd3, 2'd1, 1'b1);
    dram_dout = '0; sys_bus_dout = '0; dram_ready = 1'b0; sys_bus_ready = 1'b0;
    #2;
    chk_all_zero("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    nop();

    // Single-cycle accesses and pass-through instructions
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].dram, vecs[i].rc, vecs[i].wc, vecs[i].addr,
            64'h1000 + 64'(i * 4), 5'(i + 1), 2'(i), vecs[i].en);
      dram_dout     = vecs[i].dram ? vecs[i].dout : ~vecs[i].dout;
      sys_bus_dout  = vecs[i].dram ? ~vecs[i].dout : vecs[i].dout;
      dram_ready    = vecs[i].d_rdy;
      sys_bus_ready = vecs[i].b_rdy;
      #1;
      chk($sformatf("vec%0d.busy", i), mem_busy, 64'd0);
      push(64'h1000 + 64'(i * 4), 2'(i), vecs[i].en, vecs[i].addr, 5'(i + 1), vecs[i].exp_load);
      @(posedge clk);
      #1;
      pop_check($sformatf("vec%0d", i));
    end
    nop();

    // Stall holds the registers for two cycles
    drive(1'b0, RD_NONE, 3'b000, 64'hAAAA, 64'h2000, 5'd2, 2'd1, 1'b1);
    push(64'h2000, 2'd1, 1'b1, 64'hAAAA, 5'd2, 64'd0);
    @(posedge clk); #1;
    pop_check("pre_stall");
    drive(1'b0, RD_NONE, 3'b000, 64'h1234, 64'h2004, 5'd5, 2'd2, 1'b1);
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d.rd", c), rd_MEMD, 64'd2);
      chk($sformatf("stall%0d.alu", c), alu_result_MEMD, 64'hAAAA);
    end
    stall = 1'b0;
    push(64'h2004, 2'd2, 1'b1, 64'h1234, 5'd5, 64'd0);
    @(posedge clk); #1;
    pop_check("stall_rel");

    // Bus LHU completing on the fourth cycle, stray DRAM ready ignored
    b0 = busy_cycles;
    drive(1'b0, RD_LHU, 3'b000, 64'h1000_0006, 64'h2100, 5'd6, 2'd1, 1'b1);
    sys_bus_dout = 64'hBEEF_0000_0000_0000;
    dram_dout    = 64'h1111_2222_3333_4444;
    dram_ready   = 1'b1;
    sys_bus_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bubble%0d.en", c), rf_wr_en_MEMD, 64'd0);
    end
    sys_bus_ready = 1'b1;
    push(64'h2100, 2'd1, 1'b1, 64'h1000_0006, 5'd6, 64'h0000_0000_0000_BEEF);
    @(posedge clk); #1;
    pop_check("lhu_wait");
    chk("lhu_wait.busy_cycles", 64'(busy_cycles - b0), 64'd3);
    nop();

    // DRAM access with only the bus ready stays busy
    drive(1'b1, RD_LW, 3'b000, 64'h8000_0004, 64'h2200, 5'd8, 2'd1, 1'b1);
    dram_dout = D;
    sys_bus_dout = 64'd0;
    sys_bus_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("wrongdev%0d.busy", c), mem_busy, 64'd1);
      @(posedge clk); #1;
    end
    dram_ready = 1'b1;
    #1;
    chk("wrongdev_done.busy", mem_busy, 64'd0);
    push(64'h2200, 2'd1, 1'b1, 64'h8000_0004, 5'd8, 64'hFFFF_FFFF_F1E2_D3C4);
    @(posedge clk); #1;
    pop_check("wrongdev");
    nop();

    // Bus read that never completes
    b0 = busy_cycles;
    e0 = err_pulses;
    err_done = 1'b0;
    drive(1'b0, RD_LD, 3'b000, 64'h1000_0010, 64'h2300, 5'd9, 2'd1, 1'b1);
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (!err_done && err_pulses != e0) begin
        chk("timeout.load", load_data_MEMD, 64'd0);
        chk("timeout.en", rf_wr_en_MEMD, 64'd0);
        nop();
        err_done = 1'b1;
      end
    end
    chk("timeout.busy_cycles", 64'(busy_cycles - b0), 64'd255);
    chk("timeout.err_pulses", 64'(err_pulses - e0), 64'd1);
    nop();

    // Reset ten cycles into a wait
    drive(1'b0, RD_NONE, 3'b000, 64'h99, 64'h3000, 5'd9, 2'd3, 1'b1);
    push(64'h3000, 2'd3, 1'b1, 64'h99, 5'd9, 64'd0);
    @(posedge clk); #1;
    pop_check("pre_rst");
    e0 = err_pulses;
    drive(1'b0, RD_LW, 3'b000, 64'h1000_0020, 64'h3004, 5'd10, 2'd1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid.busy_before", mem_busy, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    chk("rst_hold.busy", mem_busy, 64'd0);
    drive(1'b0, RD_NONE, 3'b000, 64'h55, 64'h4000, 5'd7, 2'd2, 1'b1);
    reset = 1'b1;
    #1;
    chk("post_rst.busy", mem_busy, 64'd0);
    push(64'h4000, 2'd2, 1'b1, 64'h55, 5'd7, 64'd0);
    @(posedge clk); #1;
    pop_check("post_rst");
    chk("rst_mid.err_pulses", 64'(err_pulses - e0), 64'd0);
    nop();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_memd_stage.md
PIPELINE_MEMD_STAGE -- requirements
Module: pipeline_memd_stage

Interface
REQ-001 SHALL have the parameter: TIMEOUT_CYCLES, default 255, max wait cycles for a device response before abort.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard-unit freeze.
- is_dram_MEMP  in  1  access targets DRAM (else system bus).
- pc_MEMP  in  64  PC.
- rf_wr_sel_MEMP  in  2  WB data select.
- rf_wr_en_MEMP  in  1  RF write enable.
- alu_result_MEMP  in  64  ALU result / access address.
- rd_MEMP  in  5  destination register.
- rd_ctrl_MEMP  in  3  load type.
- wr_ctrl_MEMP  in  3  store type; nonzero = store.
- dram_dout  in  64  DRAM read data.
- dram_ready  in  1  DRAM completion.
- sys_bus_dout  in  64  bus read data.
- sys_bus_ready  in  1  bus completion.
- mem_busy  out  1  combinational stall request to all upstream stages.
- bus_err  out  1  one-cycle timeout pulse.
- pc_MEMD, rf_wr_sel_MEMD, rf_wr_en_MEMD, alu_result_MEMD, rd_MEMD  out  64/2/1/64/5  registered to WB.
- load_data_MEMD  out  64  aligned, extended load result.

Function
REQ-003 SHALL decode rd_ctrl: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWU, 111 LD.
REQ-004 SHALL treat an access as pending when rd_ctrl_MEMP or wr_ctrl_MEMP is nonzero; the device is DRAM if is_dram_MEMP=1, else the system bus.
REQ-005 SHALL implement the FSM IDLE, WAIT, ERR.
REQ-006 IDLE, no pending access: SHALL register all pass-through fields when stall=0, with load_data_MEMD=0 and latency 1 cycle.
REQ-007 IDLE, pending access and selected ready=1 in the same cycle: SHALL complete in that cycle, registering results at the next edge.
REQ-008 IDLE, pending access and selected ready=0: SHALL go to WAIT, clear the cycle counter, and assert mem_busy in that cycle.
REQ-009 WAIT: SHALL assert mem_busy and increment the 8-bit-wide counter each cycle; ready=1 completes, registers results, and returns to IDLE with mem_busy low in that cycle.
REQ-010 WAIT: when counter reaches TIMEOUT_CYCLES-1 without ready, SHALL go to ERR.
REQ-011 ERR: SHALL pulse bus_err for exactly 1 cycle, register load_data_MEMD=0 and rf_wr_en_MEMD=0, deassert mem_busy, and return to IDLE.
REQ-012 While mem_busy=1, SHALL drive rf_wr_en_MEMD=0 each cycle, inserting a bubble toward WB.
REQ-013 While mem_busy=1, SHALL hold the MEMP inputs stable; the block relies on upstream honouring mem_busy.
REQ-014 Ready from the non-selected device SHALL be ignored.
REQ-015 Ready with no pending access SHALL be ignored.
REQ-016 Alignment SHALL use offset = alu_result_MEMP[2:0]: bytes use [2:0], halves [2:1], words [2], doubles none; ignored low bits are not an error.
REQ-017 LB/LH/LW SHALL sign-extend, LBU/LHU/LWU SHALL zero-extend, and LD SHALL pass 64 bits unchanged.
REQ-018 For stores, load_data_MEMD SHALL be 0.
REQ-019 When stall=1 and mem_busy=0, all output registers and FSM state SHALL hold.
REQ-020 Priority SHALL be reset > FSM busy/complete > stall.

Reset
REQ-021 On reset low, SHALL return the FSM to IDLE and clear the counter.
REQ-022 On reset low, SHALL set all outputs to 0, including mem_busy and bus_err.
REQ-023 Reset asserted mid-WAIT SHALL abort the access with no bus_err pulse.
REQ-024 After reset deassertion, the first edge SHALL behave as IDLE.

Structure
REQ-025 Package pipeline_mem_pkg SHALL hold the rd_ctrl encoding constants, the FSM state enum, and the default TIMEOUT_CYCLES.
REQ-026 SHALL instantiate one combinational sub-module, load_align (rd_ctrl, offset, 64-bit raw data -> 64-bit extended data).
REQ-027 The FSM and pipeline registers SHALL live in pipeline_memd_stage.

Verification
REQ-028 DRAM LB: addr 0x8000_0003, dram_dout=0x0000_0000_80_000000, ready same cycle -> load_data_MEMD=0xFFFF_FFFF_FFFF_FF80 next cycle; mem_busy never high.
REQ-029 Bus LHU: addr 0x1000_0006, sys_bus_ready after 3 cycles, dout[63:48]=0xBEEF -> mem_busy high exactly 3 cycles; rf_wr_en_MEMD=0 during them; then load_data=0x0000_0000_0000_BEEF.
REQ-030 Timeout: bus read with ready never asserted -> mem_busy high 255 cycles, bus_err 1-cycle pulse, load_data=0, rf_wr_en_MEMD=0.
REQ-031 Reset mid-WAIT at cycle 10 -> all outputs 0, FSM IDLE, no bus_err; next non-memory instruction passes with 1-cycle latency.
REQ-032 stall=1 for 2 cycles with ALU instruction (rd=5, result 0x1234) -> outputs hold; after release, rd_MEMD=5, alu_result_MEMD=0x1234.
REQ-033 Wrong-device ready: DRAM access with sys_bus_ready=1, dram_ready=0 -> remains in WAIT with mem_busy=1.
